// File: rtl/periph_bus_sequencer.sv
// -----------------------------------------------------------------------------
// periph_bus_sequencer
//   Arbitrates the shared peripheral register bus between two masters
//   (A = host command parser, B = internal master such as the telemetry
//   poller). Round-robin arbitration picks one request. The FSM then runs it
//   as a timed select strobe to one peripheral and returns the captured read
//   data and reply size.
//
// Ports
//   clk_12MHz, reset      system clock, synchronous active-high reset
//   databus               shared 32-bit data bus (driven only on writes)
//   reg_size              reply size from the selected peripheral
//   register_addr, rw     address / direction presented to the peripherals
//   select                one-hot peripheral select
//   busy                  high whenever the sequencer is not idle
//   {a,b}_valid/periph/addr/rw/wdata   per-master request fields
//   {a,b}_done            one-cycle completion pulse to the granted master
//   rdata, rsize          captured read data / size, updated on each done
//   err                   with done: peripheral index was out of range
// -----------------------------------------------------------------------------
// state   | meaning
// IDLE    | waiting for a request; grant decided here
// SETUP   | address/rw (and write data) presented, select low
// STROBE  | select high for HOLD_CYCLES cycles; capture on the last one
// RELEASE | select low, bus released, done pulse to the owner
// -----------------------------------------------------------------------------
module periph_bus_sequencer #(
    parameter int NUM_PERIPH  = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk_12MHz,
    input  logic                  reset,
    inout  wire  [31:0]           databus,
    input  logic [2:0]            reg_size,
    output logic [7:0]            register_addr,
    output logic                  rw,
    output logic [NUM_PERIPH-1:0] select,
    output logic                  busy,
    input  logic                  a_valid,
    input  logic [3:0]            a_periph,
    input  logic [7:0]            a_addr,
    input  logic                  a_rw,
    input  logic [31:0]           a_wdata,
    output logic                  a_done,
    input  logic                  b_valid,
    input  logic [3:0]            b_periph,
    input  logic [7:0]            b_addr,
    input  logic                  b_rw,
    input  logic [31:0]           b_wdata,
    output logic                  b_done,
    output logic [31:0]           rdata,
    output logic [2:0]            rsize,
    output logic                  err
);

    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          last_b_q, last_b_d;    // 1: B was granted last
    logic          owner_b_q, owner_b_d;  // 1: current transaction belongs to B
    logic [3:0]    periph_q, periph_d;
    logic [7:0]    addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [2:0]    rsize_q, rsize_d;

    logic          grant_b;
    logic          in_range;
    logic          drive_bus;

    // Widen by one bit so NUM_PERIPH = 16 still compares correctly.
    assign in_range = ({1'b0, periph_q} < 5'(NUM_PERIPH));

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;   // so A wins the first contention
            owner_b_q <= 1'b0;
            periph_q  <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            rsize_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            owner_b_q <= owner_b_d;
            periph_q  <= periph_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rsize_q   <= rsize_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        owner_b_d = owner_b_q;
        periph_d  = periph_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rsize_d   = rsize_q;
        grant_b   = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_valid || b_valid) begin
                    // B wins when it is alone or when A was served last.
                    grant_b   = b_valid && (!a_valid || !last_b_q);
                    owner_b_d = grant_b;
                    last_b_d  = grant_b;
                    periph_d  = grant_b ? b_periph : a_periph;
                    addr_d    = grant_b ? b_addr   : a_addr;
                    rw_d      = grant_b ? b_rw     : a_rw;
                    wdata_d   = grant_b ? b_wdata  : a_wdata;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CW'(HOLD_CYCLES - 1);
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    rdata_d = in_range ? databus  : 32'd0;
                    rsize_d = in_range ? reg_size : 3'd0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        select = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            select[i] = (state_q == STROBE) && (periph_q == 4'(i));
        end
    end

    // Write data is on the bus from SETUP through the end of STROBE, so it is
    // already settled when select rises; the bus is never driven on reads.
    assign drive_bus     = !rw_q && ((state_q == SETUP) || (state_q == STROBE));
    assign databus       = drive_bus ? wdata_q : 32'bz;

    assign register_addr = addr_q;
    assign rw            = rw_q;
    assign busy          = (state_q != IDLE);
    assign a_done        = (state_q == RELEASE) && !owner_b_q;
    assign b_done        = (state_q == RELEASE) &&  owner_b_q;
    assign err           = (state_q == RELEASE) && !in_range;
    assign rdata         = rdata_q;
    assign rsize         = rsize_q;

endmodule

// File: tb/tb_periph_bus_sequencer.sv
module tb_periph_bus_sequencer;

    localparam int NP = 8;
    localparam int HC = 4;

    logic          clk_12MHz = 1'b0;
    logic          reset;
    wire  [31:0]   databus;
    logic [2:0]    reg_size;
    logic [7:0]    register_addr;
    logic          rw;
    logic [NP-1:0] select;
    logic          busy;
    logic          a_valid, b_valid;
    logic [3:0]    a_periph, b_periph;
    logic [7:0]    a_addr, b_addr;
    logic          a_rw, b_rw;
    logic [31:0]   a_wdata, b_wdata;
    logic          a_done, b_done;
    logic [31:0]   rdata;
    logic [2:0]    rsize;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Peripheral model: sees select one cycle after it rises, drives its
    // read value from the cycle after that.
    logic [31:0] per_val;
    logic [2:0]  per_size;
    logic        sel_seen, per_drv;

    always @(posedge clk_12MHz) begin
        if (reset) begin
            sel_seen <= 1'b0;
            per_drv  <= 1'b0;
        end else begin
            sel_seen <= (select != '0) && rw;
            per_drv  <= sel_seen && (select != '0) && rw;
        end
    end

    assign databus  = per_drv ? per_val : 32'bz;
    assign reg_size = per_drv ? per_size : 3'd0;

    periph_bus_sequencer #(.NUM_PERIPH(NP), .HOLD_CYCLES(HC)) dut (
        .clk_12MHz    (clk_12MHz),
        .reset        (reset),
        .databus      (databus),
        .reg_size     (reg_size),
        .register_addr(register_addr),
        .rw           (rw),
        .select       (select),
        .busy         (busy),
        .a_valid      (a_valid),
        .a_periph     (a_periph),
        .a_addr       (a_addr),
        .a_rw         (a_rw),
        .a_wdata      (a_wdata),
        .a_done       (a_done),
        .b_valid      (b_valid),
        .b_periph     (b_periph),
        .b_addr       (b_addr),
        .b_rw         (b_rw),
        .b_wdata      (b_wdata),
        .b_done       (b_done),
        .rdata        (rdata),
        .rsize        (rsize),
        .err          (err)
    );

    always #5 clk_12MHz = ~clk_12MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_12MHz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (checks %0d, errors %0d)", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_b;
        logic got;
        int   cnt;

        reset    = 1'b1;
        a_valid  = 1'b0; a_periph = 4'd0; a_addr = 8'd0; a_rw = 1'b0; a_wdata = 32'd0;
        b_valid  = 1'b0; b_periph = 4'd0; b_addr = 8'd0; b_rw = 1'b0; b_wdata = 32'd0;
        per_val  = 32'd0;
        per_size = 3'd0;
        repeat (3) cyc();

        // ---------------- reset values ----------------
        chk("reset select",   32'(select),        32'd0);
        chk("reset addr",     32'(register_addr), 32'd0);
        chk("reset rw",       32'(rw),            32'd0);
        chk("reset busy",     32'(busy),          32'd0);
        chk("reset done",     32'({a_done, b_done}), 32'd0);
        chk("reset rdata",    rdata,              32'd0);
        chk("reset rsize",    32'(rsize),         32'd0);
        chk("reset err",      32'(err),           32'd0);
        reset = 1'b0;
        cyc();

        // ---------------- read by A, periph 2 ----------------
        a_valid = 1'b1; a_periph = 4'd2; a_addr = 8'h01; a_rw = 1'b1; a_wdata = 32'hFFFF_0000;
        per_val = 32'h0000_1A2B; per_size = 3'd2;
        cyc();  // t+1 SETUP
        chk("rd setup select", 32'(select),        32'd0);
        chk("rd setup addr",   32'(register_addr), 32'h01);
        chk("rd setup rw",     32'(rw),            32'd1);
        chk("rd setup busy",   32'(busy),          32'd1);
        for (int k = 2; k <= 5; k++) begin
            cyc();  // t+2 .. t+5 STROBE
            chk("rd strobe select", 32'(select),        32'h04);
            chk("rd strobe addr",   32'(register_addr), 32'h01);
            chk("rd strobe done",   32'(a_done),        32'd0);
            if (k == 2) begin
                a_addr   = 8'h03;
                a_periph = 4'd5;
            end
        end
        cyc();  // t+6 RELEASE
        chk("rd done a",     32'(a_done),        32'd1);
        chk("rd done b",     32'(b_done),        32'd0);
        chk("rd rdata",      rdata,              32'h0000_1A2B);
        chk("rd rsize",      32'(rsize),         32'd2);
        chk("rd err",        32'(err),           32'd0);
        chk("rd rel select", 32'(select),        32'd0);
        chk("rd rel addr",   32'(register_addr), 32'h01);
        a_valid = 1'b0;
        cyc();  // t+7 IDLE
        chk("rd idle done",  32'(a_done),        32'd0);
        chk("rd idle busy",  32'(busy),          32'd0);
        chk("rd rdata held", rdata,              32'h0000_1A2B);
        chk("rd addr held",  32'(register_addr), 32'h01);
        cyc();
        chk("rd no reserve", 32'(busy),          32'd0);

        // ---------------- write by B, periph 0 ----------------
        b_valid = 1'b1; b_periph = 4'd0; b_addr = 8'h00; b_rw = 1'b0; b_wdata = 32'h0000_0002;
        cyc();  // t+1 SETUP
        chk("wr setup bus",    databus,            32'h2);
        chk("wr setup select", 32'(select),        32'd0);
        chk("wr setup rw",     32'(rw),            32'd0);
        chk("wr setup addr",   32'(register_addr), 32'h00);
        for (int k = 2; k <= 5; k++) begin
            cyc();
            chk("wr strobe bus",    databus,     32'h2);
            chk("wr strobe select", 32'(select), 32'h01);
            chk("wr strobe done",   32'(b_done), 32'd0);
        end
        cyc();  // t+6 RELEASE
        chk("wr done b",     32'(b_done),              32'd1);
        chk("wr done a",     32'(a_done),              32'd0);
        chk("wr rel select", 32'(select),              32'd0);
        chk("wr rel bus",    32'(databus !== 32'h2),   32'd1);
        b_valid = 1'b0;
        cyc();  // t+7 IDLE
        chk("wr idle bus",   32'(databus !== 32'h2),   32'd1);
        chk("wr idle done",  32'(b_done),              32'd0);
        chk("wr idle busy",  32'(busy),                32'd0);

        // ---------------- out-of-range index ----------------
        a_valid = 1'b1; a_periph = 4'd9; a_addr = 8'h40; a_rw = 1'b1; a_wdata = 32'd0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("bad select", 32'(select), 32'd0);
            chk("bad busy",   32'(busy),   32'd1);
            chk("bad early",  32'(a_done), 32'd0);
        end
        cyc();  // t+6
        chk("bad done",  32'(a_done), 32'd1);
        chk("bad err",   32'(err),    32'd1);
        chk("bad rdata", rdata,       32'd0);
        chk("bad rsize", 32'(rsize),  32'd0);
        a_valid = 1'b0;
        cyc();
        chk("bad err clr", 32'(err),    32'd0);
        chk("bad done clr", 32'(a_done), 32'd0);

        // ---------------- reset during STROBE ----------------
        b_valid = 1'b1; b_periph = 4'd3; b_addr = 8'h07; b_rw = 1'b0; b_wdata = 32'hCAFE_0001;
        cyc();
        cyc();  // t+2
        chk("rst strobe select", 32'(select), 32'h08);
        cyc();  // t+3
        chk("rst pre select", 32'(select), 32'h08);
        reset = 1'b1;
        cyc();  // t+4
        chk("rst select",  32'(select),                   32'd0);
        chk("rst busy",    32'(busy),                     32'd0);
        chk("rst done",    32'({a_done, b_done}),         32'd0);
        chk("rst bus",     32'(databus !== 32'hCAFE_0001), 32'd1);
        reset   = 1'b0;
        b_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rst no done", 32'({a_done, b_done}), 32'd0);
            chk("rst idle",    32'(busy),             32'd0);
        end

        // ---------------- contention: A, B, A, B ----------------
        a_periph = 4'd1; a_addr = 8'h11; a_rw = 1'b1;
        b_periph = 4'd4; b_addr = 8'h22; b_rw = 1'b1;
        per_val  = 32'h0BAD_F00D; per_size = 3'd4;
        a_valid  = 1'b1; b_valid = 1'b1;
        exp_b    = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cnt = 0;
            got = 1'b0;
            while (!got && cnt < 12) begin
                cyc();
                cnt++;
                chk("cont both done", 32'(a_done && b_done), 32'd0);
                if (a_done || b_done) got = 1'b1;
            end
            chk("cont done seen", 32'(got),           32'd1);
            chk("cont order",     32'(b_done),        32'(exp_b));
            chk("cont latency",   32'(cnt),           32'd6);
            chk("cont addr",      32'(register_addr), exp_b ? 32'h22 : 32'h11);
            chk("cont rdata",     rdata,              32'h0BAD_F00D);
            chk("cont rsize",     32'(rsize),         32'd4);
            if (b_done) b_valid = 1'b0;
            else        a_valid = 1'b0;
            cyc();  // IDLE gap
            chk("cont idle gap",  32'(busy),          32'd0);
            a_valid = 1'b1;
            b_valid = 1'b1;
            exp_b   = !exp_b;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (10) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_bus_sequencer.md
# periph_bus_sequencer

Sequences and arbitrates the shared Uniboard peripheral register bus (databus, register_addr, rw, reg_size, per-peripheral select) between two bus masters. Requester A is the host command parser; requester B is an internal master such as the telemetry poller. Each granted transaction becomes a correctly timed select strobe to one peripheral. For reads, the sequencer captures the read value and the reply size and returns them to the requester. Arbitration is round-robin.

## Interface
- NUM_PERIPH, 8: number of peripheral select lines (1..16).
- HOLD_CYCLES, 4: cycles select is held high per transaction (min 3).
- clk_12MHz  in  1  system clock
- reset  in  1  synchronous, active-high
- databus  inout  32  shared register data bus
- reg_size  in  3  reply size in bytes, driven by the selected peripheral
- register_addr  out  8  register address to the peripherals
- rw  out  1  0 = write, 1 = read
- select  out  NUM_PERIPH  one-hot peripheral select
- busy  out  1  high whenever state is not IDLE
- a_valid, b_valid  in  1  transaction request; must stay high and stable until done
- a_periph, b_periph  in  4  target peripheral index
- a_addr, b_addr  in  8  register address
- a_rw, b_rw  in  1  direction
- a_wdata, b_wdata  in  32  write data
- a_done, b_done  out  1  one-cycle completion pulse
- rdata  out  32  captured read data; valid on the done cycle, held until the next done
- rsize  out  3  captured reg_size; valid on the done cycle, held until the next done
- err  out  1  high with done when the peripheral index is out of range

## Operation
- Reset value of every output is 0: select, register_addr, rw, busy, done pulses, rdata, rsize, err. databus is released (z). The state goes to IDLE and last_grant is set to B, so A wins first.
- The FSM has four states: IDLE, SETUP, STROBE and RELEASE.
- **IDLE**
  - If exactly one valid is high, that requester is granted.
  - If both are high, the requester that was not last_grant is granted.
  - On grant: latch periph, addr, rw and wdata; update last_grant; go to SETUP.
- **SETUP** (1 cycle)
  - register_addr and rw are driven; select is all low.
  - On a write, databus is driven with wdata.
  - Go to STROBE.
- **STROBE** (HOLD_CYCLES cycles, counted by a down-counter)
  - select[periph] is high.
  - databus is driven on writes only; on reads it is z.
  - On the final STROBE cycle, databus and reg_size are registered into rdata and rsize.
  - Go to RELEASE.
- **RELEASE** (1 cycle)
  - select is low and databus is z.
  - The granted requester's done pulses.
  - register_addr and rw hold their values.
  - Go to IDLE.
- Writes: rdata and rsize still capture bus values; requesters ignore them.
- Out-of-range peripheral (periph >= NUM_PERIPH):
  - No select is asserted and the timing is unchanged.
  - rdata = 0, rsize = 0, and err = 1 with done.
- Latched request fields are used for the whole transaction. Changes on the a_*/b_* inputs after the grant are ignored.
- valid dropping mid-transaction does not abort it; done still pulses.
- A requester sampling valid high again in the cycle after its done must not be double-served. IDLE lasts at least 1 cycle, and done must cause the master to drop valid in that same cycle.

## Timing
- Grant decided at edge t in IDLE.
- SETUP at t+1.
- STROBE at t+2 .. t+1+HOLD_CYCLES.
- RELEASE and done at t+2+HOLD_CYCLES.
- IDLE at t+3+HOLD_CYCLES.
- With the default HOLD_CYCLES = 4, done arrives 6 cycles after grant and a transaction occupies 7 cycles.
- Peripherals detect the select rising edge one cycle after it rises and load their read value one cycle later. HOLD_CYCLES >= 3 guarantees the sampled value is settled.
- The sequencer never drives databus while any select is high with rw = 1.
- Reset asserted in any state:
  - At the next edge select goes low and databus goes z.
  - No done pulse is issued and the transaction is discarded.
- Back-to-back requests with both masters always valid alternate strictly A, B, A, B.

## Test plan
- Read: a_valid, periph 2, addr 1, rw 1, peripheral returns 0x0000_1A2B with size 2 -> select[2] high for 4 cycles, a_done 6 cycles after grant, rdata 0x1A2B, rsize 2, err 0.
- Write: b_valid, periph 0, addr 0, rw 0, wdata 0x2 -> databus = 0x2 throughout SETUP and STROBE, select[0] rising edge at t+2, b_done at t+6, databus z afterwards.
- Contention: a_valid and b_valid held high for 4 transactions -> grant order A, B, A, B, with one done per transaction and never both done pulses in one cycle.
- Bad index: a_periph 9 with NUM_PERIPH 8 -> select stays 0, a_done at t+6 with err 1, rdata 0, rsize 0.
- Reset mid-STROBE: reset at t+3 -> select 0 and databus z at t+4, no done, busy 0; the next simultaneous request grants A.
- Requester changes a_addr from 1 to 3 during STROBE -> register_addr stays 1 until the next grant.
